// File: rtl/ensemble_vote_combiner_if.sv
// AXI-Stream bundle shared by the three classifier result inputs and the voted output.
interface ensemble_vote_combiner_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/ensemble_vote_combiner.sv
// Aligns three classifier result streams sample-by-sample and emits one majority-voted word.
// Optional collection timeout with late-word dropping is enabled by defining VOTE_TIMEOUT_EN.
module ensemble_vote_combiner #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned KEEP_WIDTH  = 4,
    parameter int unsigned CLASS_BITS  = 8,
    parameter int unsigned TIE_IDX     = 0,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    ensemble_vote_combiner_if.slave   s_axis_0,
    ensemble_vote_combiner_if.slave   s_axis_1,
    ensemble_vote_combiner_if.slave   s_axis_2,
    ensemble_vote_combiner_if.master  m_axis
);
    localparam logic [1:0] TieSel = 2'(TIE_IDX);

    if (DATA_WIDTH < 32 || KEEP_WIDTH != DATA_WIDTH / 8 || CLASS_BITS == 0 ||
        CLASS_BITS > 16 || TIE_IDX > 2 || TIMEOUT_CYC == 0 || TIMEOUT_CYC > 65535)
    begin : g_param_check
        $error("ensemble_vote_combiner: unsupported parameter set");
    end

    typedef enum logic [1:0] {StCollect, StVote, StOut} state_e;

    state_e                state_q;
    logic [2:0]            full_q;
    logic [CLASS_BITS-1:0] label_q [3];
    logic                  timeout_q;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic [2:0]            in_valid;
    logic [2:0]            in_ready;
    logic [2:0]            cap;
    logic [2:0]            keep_cap;
    logic [2:0]            full_next;
    logic [CLASS_BITS-1:0] in_label [3];
    logic                  all_full;
    logic                  tmo_hit;

    assign in_valid    = {s_axis_2.tvalid, s_axis_1.tvalid, s_axis_0.tvalid};
    assign in_label[0] = s_axis_0.tdata[CLASS_BITS-1:0];
    assign in_label[1] = s_axis_1.tdata[CLASS_BITS-1:0];
    assign in_label[2] = s_axis_2.tdata[CLASS_BITS-1:0];

    // Gated by rst_n so nothing is ever accepted while reset is held.
    assign in_ready        = {3{rst_n && (state_q == StCollect)}} & ~full_q;
    assign s_axis_0.tready = in_ready[0];
    assign s_axis_1.tready = in_ready[1];
    assign s_axis_2.tready = in_ready[2];

    assign cap       = in_valid & in_ready;
    assign full_next = full_q | keep_cap;
    assign all_full  = &full_next;

    logic unused_inputs;
    assign unused_inputs = ^{s_axis_0.tkeep, s_axis_0.tlast, s_axis_0.tdata[DATA_WIDTH-1:CLASS_BITS],
                             s_axis_1.tkeep, s_axis_1.tlast, s_axis_1.tdata[DATA_WIDTH-1:CLASS_BITS],
                             s_axis_2.tkeep, s_axis_2.tlast, s_axis_2.tdata[DATA_WIDTH-1:CLASS_BITS]};

`ifdef VOTE_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;
    logic [2:0]  drop_q;

    // A word arriving on a stream that missed the previous timeout is consumed, not stored.
    assign keep_cap = cap & ~drop_q;
    assign tmo_hit  = (state_q == StCollect) && (tmo_cnt_q != 16'd0) &&
                      (32'(tmo_cnt_q) >= TIMEOUT_CYC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            drop_q    <= '0;
        end else if (state_q == StCollect) begin
            if (tmo_hit && !all_full) begin
                drop_q <= (drop_q & ~cap) | ~full_next;
            end else begin
                drop_q <= drop_q & ~cap;
            end
            if (tmo_cnt_q != 16'd0) begin
                if (!tmo_hit) begin
                    tmo_cnt_q <= tmo_cnt_q + 16'd1;
                end
            end else if (|keep_cap) begin
                tmo_cnt_q <= 16'd1;
            end
        end else if (state_q == StOut && m_axis.tready) begin
            tmo_cnt_q <= '0;
        end
    end
`else
    assign keep_cap = cap;
    assign tmo_hit  = 1'b0;
`endif

    logic [CLASS_BITS-1:0] win;
    logic [2:0]            agree;
    logic [1:0]            present_cnt;
    logic                  eq01;
    logic                  eq02;
    logic                  eq12;
    logic [DATA_WIDTH-1:0] vote_word;

    always_comb begin
        eq01 = full_q[0] && full_q[1] && (label_q[0] == label_q[1]);
        eq02 = full_q[0] && full_q[2] && (label_q[0] == label_q[2]);
        eq12 = full_q[1] && full_q[2] && (label_q[1] == label_q[2]);
        if (eq01 || eq02) begin
            win = label_q[0];
        end else if (eq12) begin
            win = label_q[1];
        end else if (full_q[TieSel]) begin
            win = label_q[TieSel];
        end else if (full_q[0]) begin
            win = label_q[0];
        end else if (full_q[1]) begin
            win = label_q[1];
        end else begin
            win = label_q[2];
        end
        for (int i = 0; i < 3; i++) begin
            agree[i] = full_q[i] && (label_q[i] == win);
        end
        present_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]} + {1'b0, full_q[2]};
        vote_word                  = '0;
        vote_word[CLASS_BITS-1:0]  = win;
        vote_word[18:16]           = agree;
        vote_word[20:19]           = present_cnt;
        vote_word[30]              = timeout_q;
        vote_word[31]              = eq01 && eq02;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StCollect;
            full_q      <= '0;
            timeout_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                label_q[i] <= '0;
            end
        end else begin
            case (state_q)
                StCollect: begin
                    for (int i = 0; i < 3; i++) begin
                        if (keep_cap[i]) begin
                            full_q[i]  <= 1'b1;
                            label_q[i] <= in_label[i];
                        end
                    end
                    if (all_full || tmo_hit) begin
                        timeout_q <= !all_full;
                        state_q   <= StVote;
                    end
                end
                StVote: begin
                    out_data_q  <= vote_word;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
                end
                StOut: begin
                    if (m_axis.tready) begin
                        out_valid_q <= 1'b0;
                        full_q      <= '0;
                        timeout_q   <= 1'b0;
                        state_q     <= StCollect;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end

    assign m_axis.tdata  = out_data_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tkeep  = {KEEP_WIDTH{out_valid_q}};
    assign m_axis.tlast  = out_valid_q;
endmodule

// File: tb/tb_ensemble_vote_combiner.sv
// Directed bench for ensemble_vote_combiner with a scoreboard of expected voted words.
module tb_ensemble_vote_combiner;
    localparam int unsigned DW  = 32;
    localparam int unsigned KW  = 4;
    localparam int unsigned CB  = 8;
    localparam int unsigned TIE = 1;
    localparam int unsigned TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          rise_q[$];
    logic        prev_valid = 1'b0;
    int          last_cap = 0;
    int          rc;
    int          rc2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s0 ();
    ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s1 ();
    ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s2 ();
    ensemble_vote_combiner_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) m ();

    ensemble_vote_combiner #(
        .DATA_WIDTH (DW),
        .KEEP_WIDTH (KW),
        .CLASS_BITS (CB),
        .TIE_IDX    (TIE),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_axis_0(s0),
        .s_axis_1(s1),
        .s_axis_2(s2),
        .m_axis  (m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference vote: first equal pair wins, else tie index, else lowest present slot.
    function automatic logic [31:0] model(input logic [2:0] p, input logic [31:0] a, b, c,
                                          input logic tmo);
        logic [7:0]  l [3];
        logic [7:0]  w;
        logic        found;
        logic [2:0]  ag;
        int          n;
        logic [31:0] r;
        l[0] = a[7:0];
        l[1] = b[7:0];
        l[2] = c[7:0];
        found = 1'b0;
        w = 8'd0;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 3; j++) begin
                if (!found && p[i] && p[j] && l[i] == l[j]) begin
                    w = l[i];
                    found = 1'b1;
                end
            end
        end
        if (!found) begin
            if (p[TIE]) w = l[TIE];
            else begin
                for (int i = 2; i >= 0; i--) if (p[i]) w = l[i];
            end
        end
        for (int i = 0; i < 3; i++) begin
            ag[i] = p[i] && (l[i] == w);
            n += int'(p[i]);
        end
        r = 32'd0;
        r[7:0]   = w;
        r[18:16] = ag;
        r[20:19] = 2'(n);
        r[30]    = tmo;
        r[31]    = (p == 3'b111) && (l[0] == l[1]) && (l[1] == l[2]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (m.tvalid && !prev_valid) rise_q.push_back(cyc);
            if (m.tvalid && m.tready) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_output observed=%h expected=none", m.tdata);
                end
                if (exp_q.size() != 0) begin
                    chk("out_data", m.tdata, exp_q.pop_front());
                    chk("out_keep", {28'd0, m.tkeep}, 32'hf);
                    chk("out_last", {31'd0, m.tlast}, 32'd1);
                end
            end
        end
        prev_valid <= m.tvalid;
    end

    task automatic drive3(input logic [2:0] en, input logic [31:0] d0, d1, d2);
        logic [2:0] pend;
        logic [2:0] acc;
        pend = en;
        s0.tdata = d0;
        s1.tdata = d1;
        s2.tdata = d2;
        s0.tvalid = en[0];
        s1.tvalid = en[1];
        s2.tvalid = en[2];
        for (int k = 0; k < 100 && pend != 3'b000; k++) begin
            @(negedge clk);
            acc = pend & {s2.tready, s1.tready, s0.tready};
            if (acc != 3'b000) last_cap = cyc;
            @(posedge clk);
            #1;
            pend = pend & ~acc;
            s0.tvalid = pend[0];
            s1.tvalid = pend[1];
            s2.tvalid = pend[2];
        end
        chk("drive_accept", {29'd0, pend}, 32'd0);
    endtask

    task automatic wait_rise(input string tag, output int c);
        c = -1;
        for (int k = 0; k < 100 && rise_q.size() == 0; k++) @(posedge clk);
        checks++;
        assert (rise_q.size() != 0) else begin
            errors++;
            $error("FAIL %s observed=no_tvalid expected=tvalid_rise", tag);
        end
        if (rise_q.size() != 0) c = rise_q.pop_front();
    endtask

    task automatic wait_drain(input string tag);
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        chk(tag, exp_q.size(), 32'd0);
    endtask

    function automatic logic [31:0] readies();
        return {29'd0, s2.tready, s1.tready, s0.tready};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s0.tvalid = 1'b0; s1.tvalid = 1'b0; s2.tvalid = 1'b0;
        s0.tdata = '0; s1.tdata = '0; s2.tdata = '0;
        s0.tkeep = '1; s1.tkeep = '1; s2.tkeep = '1;
        s0.tlast = 1'b1; s1.tlast = 1'b1; s2.tlast = 1'b1;
        m.tready = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_tvalid", {31'd0, m.tvalid}, 32'd0);
        chk("rst_tkeep", {28'd0, m.tkeep}, 32'd0);
        chk("rst_tlast", {31'd0, m.tlast}, 32'd0);
        chk("rst_tdata", m.tdata, 32'd0);
        chk("rst_ready", readies(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", readies(), 32'd7);
        @(posedge clk);
        #1;

        // Unanimous same-cycle sample.
        exp_q.push_back(32'h801F_0003);
        drive3(3'b111, 32'd3, 32'd3, 32'd3);
        wait_rise("t1_rise", rc);
        chk("t1_latency", rc - last_cap, 32'd2);
        wait_drain("t1_drain");

        // Staggered arrivals, majority 5 from slots 0 and 2.
        exp_q.push_back(32'h001D_0005);
        drive3(3'b001, 32'd5, 32'd0, 32'd0);
        chk("t2_ready_after0", readies(), 32'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("t2_no_early_valid", {31'd0, m.tvalid}, 32'd0);
        drive3(3'b010, 32'd0, 32'd2, 32'd0);
        chk("t2_ready_after1", readies(), 32'd4);
        repeat (4) @(posedge clk);
        #1;
        drive3(3'b100, 32'd0, 32'd0, 32'd5);
        wait_rise("t2_rise", rc);
        chk("t2_latency", rc - last_cap, 32'd2);
        wait_drain("t2_drain");

        // Three-way disagreement resolved by TIE_IDX=1, output held under backpressure.
        m.tready = 1'b0;
        exp_q.push_back(32'h001A_0002);
        drive3(3'b111, 32'd1, 32'd2, 32'd4);
        wait_rise("t3_rise", rc);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("t3_hold_data", m.tdata, 32'h001A_0002);
            chk("t3_hold_valid", {31'd0, m.tvalid}, 32'd1);
            chk("t3_hold_ready", readies(), 32'd0);
        end
        @(posedge clk);
        #1;
        m.tready = 1'b1;
        wait_drain("t3_drain");

        // Two queued samples, upper tdata bits differ but labels compare on low bits only.
        exp_q.push_back(model(3'b111, 32'h1234_560A, 32'hFEDC_BA0A, 32'h0000_000B, 1'b0));
        exp_q.push_back(model(3'b111, 32'hAA00_0014, 32'h5500_0015, 32'h0F00_0016, 1'b0));
        drive3(3'b111, 32'h1234_560A, 32'hFEDC_BA0A, 32'h0000_000B);
        drive3(3'b111, 32'hAA00_0014, 32'h5500_0015, 32'h0F00_0016);
        wait_rise("t4_rise_a", rc);
        wait_rise("t4_rise_b", rc2);
        chk("t4_spacing", rc2 - rc, 32'd3);
        wait_drain("t4_drain");

        // Reset while voting discards the sample.
        drive3(3'b111, 32'd7, 32'd7, 32'd8);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", {31'd0, m.tvalid}, 32'd0);
        chk("t5_rst_ready", readies(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Partial sample then reset: captured word must not survive.
        drive3(3'b001, 32'd9, 32'd0, 32'd0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rise_q.delete();
        @(posedge clk);
        #1;
        exp_q.push_back(model(3'b111, 32'd6, 32'd6, 32'd2, 1'b0));
        drive3(3'b111, 32'd6, 32'd6, 32'd2);
        wait_rise("t5_rise", rc);
        chk("t5_latency", rc - last_cap, 32'd2);
        wait_drain("t5_drain");

`ifdef VOTE_TIMEOUT_EN
        // Stream 1 silent: timeout vote, then its late word is dropped.
        exp_q.push_back(32'h4015_0007);
        drive3(3'b101, 32'd7, 32'd0, 32'd7);
        wait_rise("t6_rise", rc);
        chk("t6_timeout_window", {31'd0, (rc - last_cap >= 16) && (rc - last_cap <= 20)}, 32'd1);
        wait_drain("t6_drain");
        drive3(3'b010, 32'd0, 32'd99, 32'd0);
        chk("t6_drop_ready", readies(), 32'd7);
        exp_q.push_back(model(3'b111, 32'd4, 32'd4, 32'd5, 1'b0));
        drive3(3'b111, 32'd4, 32'd4, 32'd5);
        wait_rise("t6_next_rise", rc);
        wait_drain("t6_next_drain");
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("final_scoreboard", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
